// File: rtl/tmds_channel_decoder_if.sv
// Lane-side bundle between the deserializer (master) and one TMDS channel decoder (slave).
// The raw word flows in; the decoded pixel/control and lock status flow back out.
interface tmds_channel_decoder_if;
    logic [9:0] raw_in;
    logic [7:0] data_out;
    logic [1:0] c_out;
    logic       de_out;
    logic       locked;
    logic [3:0] offset;

    modport master (
        output raw_in,
        input  data_out,
        input  c_out,
        input  de_out,
        input  locked,
        input  offset
    );

    modport slave (
        input  raw_in,
        output data_out,
        output c_out,
        output de_out,
        output locked,
        output offset
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// One TMDS/DVI receive lane: bit-aligns raw 10-bit words by hunting for blanking
// control-token runs, tracks lock, and decodes to pixel byte or control pair.
//
// state     | meaning
// ST_SEARCH | hunting for C_lock_count consecutive tokens; slips offset on timeout
// ST_LOCKED | offset frozen; decoding; drops lock after C_timeout tokenless cycles
module tmds_channel_decoder #(
    parameter int C_lock_count = 16,
    parameter int C_timeout    = 2048
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    tmds_channel_decoder_if.slave  tmds
);
    localparam int RUN_W = $clog2(C_lock_count + 1);
    localparam int TMO_W = $clog2(C_timeout);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(C_lock_count);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_timeout - 1);

    typedef enum logic [0:0] {ST_SEARCH, ST_LOCKED} state_t;

    state_t           state_q, state_d;
    logic [9:0]       raw_prev_q;
    logic [9:0]       aligned_q;
    logic [19:0]      window;
    logic [3:0]       offset_q, offset_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             skip_q, skip_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       c_q, c_d;
    logic             de_q, de_d;

    logic             is_ctrl;
    logic [1:0]       ctrl_val;
    logic [7:0]       dword;
    logic [7:0]       dec_byte;

    assign window = {tmds.raw_in, raw_prev_q};

    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_val = 2'b00;
        case (aligned_q)
            10'h354: ctrl_val = 2'b00;
            10'h0AB: ctrl_val = 2'b01;
            10'h154: ctrl_val = 2'b10;
            10'h2AB: ctrl_val = 2'b11;
            default: is_ctrl  = 1'b0;
        endcase
    end

    always_comb begin
        dword       = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
        dec_byte    = 8'h00;
        dec_byte[0] = dword[0];
        for (int i = 1; i < 8; i++) begin
            dec_byte[i] = aligned_q[8] ? (dword[i] ^ dword[i-1]) : ~(dword[i] ^ dword[i-1]);
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        tmo_d    = tmo_q;
        skip_d   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (run_q == RUN_LOCK) begin
                    state_d = ST_LOCKED;
                end
                // The word latched on the slip edge still used the old offset.
                if (skip_q) begin
                    run_d = run_q;
                end else if (is_ctrl) begin
                    run_d = (run_q == RUN_LOCK) ? run_q : run_q + 1'b1;
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    run_d    = '0;
                    tmo_d    = '0;
                    skip_d   = 1'b1;
                end else begin
                    run_d = '0;
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (is_ctrl) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_SEARCH;
                    run_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        data_d = 8'h00;
        de_d   = 1'b0;
        c_d    = c_q;
        if (state_q == ST_LOCKED) begin
            if (is_ctrl) begin
                c_d = ctrl_val;
            end else begin
                de_d   = 1'b1;
                data_d = dec_byte;
            end
        end else begin
            c_d = 2'b00;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            raw_prev_q <= '0;
            aligned_q  <= '0;
            offset_q   <= '0;
            run_q      <= '0;
            tmo_q      <= '0;
            skip_q     <= 1'b0;
            data_q     <= '0;
            c_q        <= '0;
            de_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            raw_prev_q <= tmds.raw_in;
            aligned_q  <= window[{1'b0, offset_q} +: 10];
            offset_q   <= offset_d;
            run_q      <= run_d;
            tmo_q      <= tmo_d;
            skip_q     <= skip_d;
            data_q     <= data_d;
            c_q        <= c_d;
            de_q       <= de_d;
        end
    end

    assign tmds.data_out = data_q;
    assign tmds.c_out    = c_q;
    assign tmds.de_out   = de_q;
    assign tmds.locked   = (state_q == ST_LOCKED);
    assign tmds.offset   = offset_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for one TMDS lane decoder (C_timeout = 64): data bytes go through a
// scoreboard queue checked on de_out; lock, offset and control are checked inline.
module tb_tmds_channel_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .C_lock_count (16),
        .C_timeout    (64)
    ) dut (
        .clk_pixel (clk),
        .reset     (reset),
        .tmds      (bus)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [9:0] prev_w = 10'h000;
    int         rot = 0;

    logic [9:0] dw   [8] = '{10'h100, 10'h200, 10'h1FF, 10'h0FF, 10'h3F0, 10'h2F0, 10'h155, 10'h055};
    logic [7:0] dexp [8] = '{8'h00,   8'hFF,   8'h01,   8'hFF,   8'h11,   8'hEF,   8'hFF,   8'h01};

    logic [9:0] sw   [9] = '{10'h0AB, 10'h154, 10'h2AB, 10'h354, 10'h2AB, 10'h100, 10'h200, 10'h1FF, 10'h354};
    logic [1:0] ec   [9] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    logic       ed   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] edat [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Serialises logical words with a 'rot'-bit phase shift, as a misaligned deserializer would.
    task automatic send(input logic [9:0] w);
        logic [19:0] cat;
        @(negedge clk);
        cat = {w, prev_w} >> (10 - rot);
        bus.raw_in = cat[9:0];
        prev_w = w;
    endtask

    task automatic push(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 3;
        sb_q.push_back(e);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_locked"}, 32'(bus.locked), 32'd0);
        check({tag, "_offset"}, 32'(bus.offset), 32'd0);
        check({tag, "_de"},     32'(bus.de_out), 32'd0);
        check({tag, "_data"},   32'(bus.data_out), 32'd0);
        check({tag, "_c"},      32'(bus.c_out), 32'd0);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.de_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_de: got de_out=1 data 0x%0h, expected no valid output", bus.data_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("data_out", 32'(bus.data_out), 32'(mon_e.data));
                check("data_latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        int         last_off;
        int         steps[$];
        logic [9:0] w;

        bus.raw_in = 10'h000;
        repeat (3) @(negedge clk);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_offset", 32'(bus.offset), 32'd0);
        check("rst_de",     32'(bus.de_out), 32'd0);
        check("rst_data",   32'(bus.data_out), 32'd0);
        check("rst_c",      32'(bus.c_out), 32'd0);
        reset = 1'b0;

        // Offset-0 stream: lock two edges after the 16th token reaches stage 1.
        rot = 0;
        for (int i = 0; i < 16; i++) send(10'h354);
        send(10'h100);          // decoded while still searching, so never valid
        for (int i = 0; i < 6; i++) begin
            send(dw[i+2]);
            push(dexp[i+2]);
            if (i == 1) check("t1_lock_not_early", 32'(bus.locked), 32'd0);
            if (i == 2) begin
                check("t1_locked", 32'(bus.locked), 32'd1);
                check("t1_offset", 32'(bus.offset), 32'd0);
                check("t1_c_out",  32'(bus.c_out), 32'd0);
            end
        end
        for (int i = 0; i < 4; i++) send(10'h354);
        pulse_reset("t1_rst");

        // Stream shifted by 3 bits with 70-word gaps between 20-token runs.
        rot = 3;
        prev_w = 10'h000;
        last_off = 0;
        for (int i = 0; i < 400 && bus.locked !== 1'b1; i++) begin
            w = ((i % 90) < 70) ? 10'h100 : 10'h354;
            send(w);
            if (int'(bus.offset) != last_off) begin
                last_off = int'(bus.offset);
                steps.push_back(last_off);
            end
        end
        check("t2_locked", 32'(bus.locked), 32'd1);
        check("t2_offset", 32'(bus.offset), 32'd3);
        check("t2_n_steps", 32'(steps.size()), 32'd3);
        for (int j = 0; j < 3; j++) begin
            check("t2_step", (j < steps.size()) ? 32'(steps[j]) : 32'hFF, 32'(j + 1));
        end

        // Control tokens and data bytes while locked at offset 3.
        for (int s = 0; s < 12; s++) begin
            send((s < 9) ? sw[s] : 10'h2AB);
            if (s < 9 && ed[s]) push(edat[s]);
            if (s >= 3) begin
                check("t4_c_out", 32'(bus.c_out), 32'(ec[s-3]));
                check("t4_de",    32'(bus.de_out), 32'(ed[s-3]));
                check("t4_data",  32'(bus.data_out), 32'(edat[s-3]));
            end
        end

        // 64 tokenless words drop lock; the offset stays where it was found.
        for (int m = 1; m <= 68; m++) begin
            send(dw[(m - 1) % 8]);
            if (m <= 64) push(dexp[(m - 1) % 8]);
            if (m == 66) begin
                check("t5_still_locked", 32'(bus.locked), 32'd1);
                check("t5_c_hold", 32'(bus.c_out), 32'd3);
            end
            if (m == 67) begin
                check("t5_lost", 32'(bus.locked), 32'd0);
                check("t5_offset", 32'(bus.offset), 32'd3);
            end
            if (m == 68) begin
                check("t5_de", 32'(bus.de_out), 32'd0);
                check("t5_c_zero", 32'(bus.c_out), 32'd0);
            end
        end

        for (int t = 1; t <= 20; t++) begin
            send(10'h354);
            if (t == 19) check("t6_relock_not_early", 32'(bus.locked), 32'd0);
            if (t == 20) begin
                check("t6_relocked", 32'(bus.locked), 32'd1);
                check("t6_offset3", 32'(bus.offset), 32'd3);
            end
        end
        pulse_reset("t6_rst");

        repeat (4) send(10'h354);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
